// File: rtl/vx_stream_wrr_scheduler.sv
// Packet-aware weighted round-robin stream scheduler.
// Grants are held per packet and renewed for up to weight[i] packets.
module vx_stream_wrr_scheduler #(
  parameter  int NUM_REQS     = 4,
  parameter  int DATAW        = 32,
  parameter  int WEIGHTW      = 4,
  localparam int LOG_NUM_REQS = $clog2(NUM_REQS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQS*WEIGHTW-1:0] weights,
  input  logic [NUM_REQS-1:0]         valid_in,
  input  logic [NUM_REQS*DATAW-1:0]   data_in,
  input  logic [NUM_REQS-1:0]         last_in,
  output logic [NUM_REQS-1:0]         ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic                        last_out,
  output logic [LOG_NUM_REQS-1:0]     index_out,
  input  logic                        ready_out,
  output logic                        busy
);

  typedef logic [LOG_NUM_REQS-1:0] idx_t;
  typedef logic [WEIGHTW-1:0]      cred_t;
  typedef enum logic {S_IDLE, S_OWNED} state_t;

  function automatic idx_t inc_idx(idx_t x);
    if (x == idx_t'(NUM_REQS - 1)) return '0;
    return x + 1'b1;
  endfunction

  state_t state_q, state_d;
  idx_t   owner_q, owner_d;
  idx_t   ptr_q,   ptr_d;
  cred_t  credit_q, credit_d;
  logic   mid_q,   mid_d;

  logic             vout_q;
  logic [DATAW-1:0] dout_q;
  logic             lout_q;
  idx_t             iout_q;

  cred_t            w_a [NUM_REQS];
  logic [DATAW-1:0] d_a [NUM_REQS];

  logic  acc, hold, arb_vld, sel_vld, xfer;
  idx_t  base, cand, arb_sel, sel;
  cred_t cred_base, cred_dec;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_a[i] = weights[i*WEIGHTW +: WEIGHTW];
      d_a[i] = data_in[i*DATAW +: DATAW];
    end
  end

  // Owner keeps the grant mid-packet, or at a boundary while still valid.
  always_comb begin
    acc  = !vout_q | ready_out;
    hold = (state_q == S_OWNED) && (mid_q || valid_in[owner_q]);
    base = (state_q == S_OWNED) ? inc_idx(owner_q) : ptr_q;

    arb_vld = 1'b0;
    arb_sel = base;
    cand    = base;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!arb_vld && valid_in[cand] && w_a[cand] != '0) begin
        arb_vld = 1'b1;
        arb_sel = cand;
      end
      cand = inc_idx(cand);
    end

    sel     = hold ? owner_q : arb_sel;
    sel_vld = hold ? valid_in[owner_q] : arb_vld;
    xfer    = acc & sel_vld;

    ready_in      = '0;
    ready_in[sel] = xfer;

    cred_base = hold ? credit_q : w_a[sel];
    cred_dec  = cred_base - 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    mid_d    = mid_q;
    if (acc) begin
      if (!hold && state_q == S_OWNED) begin
        state_d = S_IDLE;
        ptr_d   = inc_idx(owner_q);
      end
      if (xfer) begin
        owner_d = sel;
        if (last_in[sel]) begin
          mid_d = 1'b0;
          if (cred_dec == '0) begin
            state_d  = S_IDLE;
            ptr_d    = inc_idx(sel);
            credit_d = '0;
          end else begin
            state_d  = S_OWNED;
            credit_d = cred_dec;
          end
        end else begin
          mid_d    = 1'b1;
          state_d  = S_OWNED;
          credit_d = cred_base;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      mid_q    <= 1'b0;
      vout_q   <= 1'b0;
      dout_q   <= '0;
      lout_q   <= 1'b0;
      iout_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      mid_q    <= mid_d;
      if (acc) begin
        vout_q <= xfer;
        if (xfer) begin
          dout_q <= d_a[sel];
          lout_q <= last_in[sel];
          iout_q <= sel;
        end
      end
    end
  end

  assign valid_out = vout_q;
  assign data_out  = dout_q;
  assign last_out  = lout_q;
  assign index_out = iout_q;
  assign busy      = (state_q == S_OWNED);

endmodule

// File: tb/tb_vx_stream_wrr_scheduler.sv
// Randomized bench for vx_stream_wrr_scheduler against a
// cycle-level behavioural model of the WRR packet rules.
module tb_vx_stream_wrr_scheduler;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int LG = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*WW-1:0] weights;
  logic [N-1:0]    valid_in, last_in, ready_in;
  logic [N*DW-1:0] data_in;
  logic            valid_out, last_out, ready_out, busy;
  logic [DW-1:0]   data_out;
  logic [LG-1:0]   index_out;

  vx_stream_wrr_scheduler #(.NUM_REQS(N), .DATAW(DW), .WEIGHTW(WW)) dut (
    .clk(clk), .reset(reset), .weights(weights),
    .valid_in(valid_in), .data_in(data_in), .last_in(last_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .last_out(last_out), .index_out(index_out),
    .ready_out(ready_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model state: owner -1 means nobody holds the grant
  int m_ptr, m_own, m_cred;
  bit m_mid, m_ov, m_ol;
  int m_oi;
  logic [DW-1:0] m_od;

  // traffic sources
  int rem [N];
  int seq [N];
  int fixlen [N];
  bit en [N];
  int w [N];
  int maxlen = 4;
  int pv = 100;
  int pr = 100;

  int obs_idx [$];
  bit obs_last [$];

  task automatic model_reset();
    m_ptr = 0; m_own = -1; m_cred = 0; m_mid = 0;
    m_ov = 0; m_ol = 0; m_oi = 0; m_od = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    valid_in = '0;
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_index", index_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_data", data_out, 0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic step();
    bit acc, xf, fresh;
    int g, j;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0)
        rem[i] = (fixlen[i] != 0) ? fixlen[i] : $urandom_range(1, maxlen);
      valid_in[i] = en[i] && ($urandom_range(0, 99) < pv);
      last_in[i]  = (rem[i] == 1);
      data_in[i*DW +: DW] = {8'(i), 8'h5a, 16'(seq[i])};
      weights[i*WW +: WW] = WW'(w[i]);
    end
    ready_out = ($urandom_range(0, 99) < pr);
    #1;
    chk("valid_out", valid_out, m_ov);
    if (m_ov) begin
      chk("data_out", data_out, m_od);
      chk("last_out", last_out, m_ol);
      chk("index_out", index_out, m_oi);
    end
    chk("busy", busy, m_own >= 0);
    if (valid_out) begin
      obs_idx.push_back(int'(index_out));
      obs_last.push_back(last_out);
    end

    acc = !m_ov || ready_out;
    g = -1;
    fresh = 0;
    if (acc) begin
      if (m_own >= 0 && (m_mid || valid_in[m_own])) begin
        g = m_own;
      end else begin
        if (m_own >= 0) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && valid_in[j] && w[j] != 0) begin
            g = j;
            fresh = 1;
          end
        end
      end
    end
    xf = (g >= 0) && valid_in[g];
    exp_rdy = '0;
    if (xf) exp_rdy[g] = 1'b1;
    chk("ready_in", ready_in, exp_rdy);

    if (acc) begin
      m_ov = xf;
      if (xf) begin
        m_od = data_in[g*DW +: DW];
        m_ol = last_in[g];
        m_oi = g;
        seq[g]++;
        rem[g]--;
        if (fresh) begin
          m_own = g;
          m_cred = w[g];
        end
        if (last_in[g]) begin
          m_mid = 0;
          m_cred--;
          if (m_cred == 0) begin
            m_own = -1;
            m_ptr = (g + 1) % N;
          end
        end else begin
          m_mid = 1;
        end
      end
    end
  endtask

  task automatic setup(int w0, int w1, int w2, int w3, int len);
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < N; i++) begin
      fixlen[i] = len;
      en[i] = 1;
    end
    pv = 100;
    pr = 100;
    obs_idx.delete();
    obs_last.delete();
  endtask

  initial begin
    int cnt1;
    int patb [6];
    patb = '{0, 0, 0, 1, 2, 3};
    valid_in = '0; last_in = '0; data_in = '0;
    weights = '0; ready_out = 1'b1;
    model_reset();
    setup(1, 1, 1, 1, 1);
    do_reset();

    // plain round robin
    for (int s = 0; s < 12; s++) step();
    chk("A_count", obs_idx.size(), 11);
    for (int s = 0; s < 8; s++) chk($sformatf("A_seq%0d", s), obs_idx[s], s % 4);

    // weight 3 on requester 0
    do_reset();
    setup(3, 1, 1, 1, 1);
    for (int s = 0; s < 14; s++) step();
    for (int s = 0; s < 12; s++) chk($sformatf("B_seq%0d", s), obs_idx[s], patb[s % 6]);

    // multi-beat packet does not interleave
    do_reset();
    setup(1, 1, 1, 1, 1);
    en[2] = 0; en[3] = 0; fixlen[0] = 4;
    for (int s = 0; s < 8; s++) step();
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("C_idx%0d", s), obs_idx[s], (s < 4) ? 0 : 1);
      chk($sformatf("C_last%0d", s), obs_last[s], s >= 3);
    end

    // downstream stall for five cycles
    do_reset();
    setup(1, 1, 1, 1, 2);
    for (int s = 0; s < 14; s++) begin
      pr = (s >= 3 && s < 8) ? 0 : 100;
      step();
    end

    // randomized rounds, weights change between rounds
    cnt1 = 0;
    for (int r = 0; r < 6; r++) begin
      setup(0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 3);
      if (r == 2 || r == 3) w[1] = 0;
      if (r == 2) do_reset();
      pv = 70;
      pr = 60;
      maxlen = 4;
      for (int s = 0; s < 400; s++) begin
        if (r == 4 && s == 200) do_reset();
        step();
      end
      if (r == 2 || r == 3)
        foreach (obs_idx[k]) if (obs_idx[k] == 1) cnt1++;
    end
    chk("w0_never_granted", cnt1, 0);

    // pointer restarts at requester 0 after reset
    setup(1, 1, 1, 1, 1);
    do_reset();
    for (int s = 0; s < 3; s++) step();
    chk("restart_first", obs_idx[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vx_stream_wrr_scheduler.md
Name: vx_stream_wrr_scheduler

Overview:
- Packet-aware weighted round-robin scheduler that shares one output stream among NUM_REQS requester streams.
- Each grant is held for a whole packet; the owner keeps the grant for up to weight[i] consecutive packets.
- Used in front of shared memory/cache request ports where requesters issue multi-beat packets that must not interleave.
- Output is registered (1-cycle latency, full throughput).

Parameters:
- NUM_REQS, 4, number of requester streams (≥2).
- DATAW, 32, payload width per beat.
- WEIGHTW, 4, width of per-requester packet-quota field.
- LOG_NUM_REQS, CLOG2(NUM_REQS), derived; not overridable.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- weights  input  NUM_REQS*WEIGHTW  per-requester packet quota; 0 = requester disabled.
- valid_in  input  NUM_REQS  per-requester beat valid.
- data_in  input  NUM_REQS*DATAW  per-requester beat payload.
- last_in  input  NUM_REQS  marks final beat of a packet.
- ready_in  output  NUM_REQS  per-requester accept; at most one bit set.
- valid_out  output  1  registered output valid.
- data_out  output  DATAW  registered payload.
- last_out  output  1  registered last flag.
- index_out  output  LOG_NUM_REQS  source requester of the output beat.
- ready_out  input  1  downstream accept.
- busy  output  1  a grant is currently held (mid-packet or mid-quota).

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: valid_out=0, data_out=0, last_out=0, index_out=0, busy=0.
  - Internal: rr pointer=0, owner none, credit=0, mid_packet=0.
- Transfer conditions:
  - Internal accept: acc = !valid_out | ready_out.
  - An input beat transfers when valid_in[sel] & ready_in[sel].
  - ready_in[sel] = acc & (state allows sel). All other ready_in bits are 0.
- Output stage:
  - On acc, the register loads {valid, data, last, index} of the selected beat, or valid_out=0 if none is selected.
  - Latency is 1 cycle; back-to-back beats are accepted at 1/cycle when ready_out=1.
- State IDLE (no owner):
  - sel = first requester at or after the rr pointer (circular) with valid_in=1 and weights!=0.
  - The grant is combinational, so the transfer occurs in the same cycle (no bubble).
  - On transfer, sample credit = weights[sel]. The beat counts toward the first packet.
  - If last_in: credit-1==0 → remain IDLE, pointer=sel+1 mod NUM_REQS. Otherwise → OWNED at a packet boundary with credit-1.
  - If not last_in → OWNED mid-packet.
- State OWNED(owner, credit, mid_packet):
  - Only the owner may transfer.
  - A last-beat transfer decrements credit and clears mid_packet.
  - When credit reaches 0 on a last beat → IDLE, pointer=owner+1.
  - Packet boundary (mid_packet=0) with owner valid_in=0: release in the same cycle, pointer=owner+1, and arbitrate as IDLE in that cycle (zero-bubble handoff).
  - Mid-packet: the grant is held indefinitely, even if owner valid_in drops or its weight changes to 0.
- Weights:
  - Weights are sampled only at grant start; later changes apply to the next grant.
  - weights[i]=0 excludes requester i from IDLE arbitration.
  - WEIGHTW arithmetic is unsigned; credit never underflows (release occurs at 0).
- busy = state==OWNED.
- No valid requester in IDLE: valid_out loads 0 on acc and the pointer is unchanged.
- When ready_out=0 and valid_out=1, all ready_in are 0 and the internal state is frozen.
- Reset asserted mid-packet: everything returns to reset values immediately. Partial packets are dropped; no recovery is attempted.

Test Plan:
- Reset, then all 4 requesters stream 1-beat packets, weights={1,1,1,1}, ready_out=1 → index_out sequence 0,1,2,3,0,… with valid_out continuously 1 from the 2nd cycle after the first valid.
- weights={3,1,1,1}, all requesters continuous 1-beat packets → index_out pattern 0,0,0,1,2,3 repeating.
- Req0 sends a 4-beat packet while req1 is valid throughout → 4 consecutive beats from index 0, last_out on the 4th; ready_in[1]=0 during them; req1 is granted on the next beat.
- Req2 idles mid-packet for 3 cycles (valid_in[2]=0) → busy=1, no other requester granted, packet resumes and completes contiguously.
- ready_out held 0 for 5 cycles with valid_out=1 → data_out stable, all ready_in=0; after release, no beat is lost or duplicated (scoreboard match).
- weights[1]=0 with req1 valid → never granted; reset pulsed low mid-packet → valid_out=0, busy=0 asynchronously, arbitration restarts at requester 0.
